// File: rtl/harness_exit_pkg.sv
// Shared types and constants for the harness end-of-test monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package harness_exit_pkg;

   // Monitor life cycle: settle after reset, run, then a terminal verdict
   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_RUN    = 2'd1,
      ST_PASS   = 2'd2,
      ST_FAIL   = 2'd3
   } state_e;

   // Why the monitor failed; REASON_NONE while not in FAIL
   typedef enum logic [1:0] {
      REASON_NONE = 2'd0,
      REASON_EXIT = 2'd1,
      REASON_WDOG = 2'd2,
      REASON_CMD  = 2'd3
   } reason_e;

   // Classification of a presented tohost word
   typedef enum logic [1:0] {
      DEC_IGNORE  = 2'd0,
      DEC_EXIT    = 2'd1,
      DEC_PUTCHAR = 2'd2,
      DEC_OTHER   = 2'd3
   } dec_e;

   // Low 64 bits of a tohost word: device, command, payload
   typedef struct packed {
      logic [7:0]  dev;
      logic [7:0]  cmd;
      logic [47:0] payload;
   } tohost_hdr_t;

   localparam logic [7:0] DEV_SYS     = 8'd0;
   localparam logic [7:0] DEV_CONSOLE = 8'd1;
   localparam logic [7:0] CMD_PUTCHAR = 8'd1;

endpackage

// File: rtl/harness_watchdog.sv
// Idle-cycle watchdog: saturating counter cleared by activity, held at zero when disabled.
// Latency: expired is combinational from the registered count and current clear/limit.
// Backpressure: none; observes activity only.
module harness_watchdog #(
   parameter int WDOG_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic [WDOG_W-1:0] limit,
   output logic              expired
);

   logic [WDOG_W-1:0] count;

   // Count idle cycles while enabled; any activity or disable restarts from zero
   always_ff @(posedge clock) begin
      if (reset || !enable || clear) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + WDOG_W'(1);
      end
   end

   // Activity in the same cycle wins over expiry; a zero limit disables it
   assign expired = enable && !clear && (limit != '0) && (count == limit);

endmodule

// File: rtl/harness_exit_monitor.sv
// End-of-test monitor: decodes tohost exit/console words, runs a watchdog, latches a sticky verdict.
// Latency: verdict, reason, code and console pulse are registered, valid the cycle after the accept.
// Backpressure: tohost_ready is low only while settling after reset; terminal states drain words.
module harness_exit_monitor
   import harness_exit_pkg::*;
#(
   parameter int DATA_W        = 64,
   parameter int CODE_W        = 32,
   parameter int WDOG_W        = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              tohost_valid,
   output logic              tohost_ready,
   input  logic [DATA_W-1:0] tohost_data,
   input  logic              heartbeat,
   input  logic [WDOG_W-1:0] wdog_limit,
   output logic              io_success,
   output logic              io_failure,
   output logic [1:0]        fail_reason,
   output logic [CODE_W-1:0] fail_code,
   output logic              console_valid,
   output logic [7:0]        console_char
);

   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

   state_e            state;
   state_e            state_nxt;
   logic [SET_W-1:0]  settle_cnt;
   tohost_hdr_t       hdr;
   dec_e              dec;
   logic              accept;
   logic              wdog_expired;
   logic [CODE_W-1:0] exit_code;
   reason_e           reason_q;
   reason_e           reason_nxt;
   logic [CODE_W-1:0] code_nxt;
   logic              putchar;

   assign hdr       = tohost_hdr_t'(tohost_data[63:0]);
   assign exit_code = tohost_data[CODE_W:1];
   assign accept    = tohost_valid && tohost_ready;

   harness_watchdog #(
      .WDOG_W (WDOG_W)
   ) u_wdog (
      .clock   (clock),
      .reset   (reset),
      .enable  (state == ST_RUN),
      .clear   (heartbeat || accept),
      .limit   (wdog_limit),
      .expired (wdog_expired)
   );

   // Classify the presented word regardless of state; only RUN acts on it
   always_comb begin
      if (hdr == '0) begin
         dec = DEC_IGNORE;
      end else if (hdr.dev == DEV_SYS && hdr.payload[0]) begin
         dec = DEC_EXIT;
      end else if (hdr.dev == DEV_CONSOLE && hdr.cmd == CMD_PUTCHAR) begin
         dec = DEC_PUTCHAR;
      end else begin
         dec = DEC_OTHER;
      end
   end

   // State register and settle countdown
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ST_SETTLE;
         settle_cnt <= SET_W'(SETTLE_CYCLES);
      end else begin
         state <= state_nxt;
         if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt - SET_W'(1);
         end
      end
   end

   // Next state plus the verdict details decided on the same edge
   always_comb begin
      state_nxt  = state;
      reason_nxt = reason_q;
      code_nxt   = fail_code;
      putchar    = 1'b0;
      unique case (state)
         ST_SETTLE: begin
            if (settle_cnt <= SET_W'(1)) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               unique case (dec)
                  DEC_EXIT: begin
                     if (exit_code == '0) begin
                        state_nxt = ST_PASS;
                     end else begin
                        state_nxt  = ST_FAIL;
                        reason_nxt = REASON_EXIT;
                        code_nxt   = exit_code;
                     end
                  end
                  DEC_PUTCHAR: putchar = 1'b1;
                  DEC_OTHER: begin
                     state_nxt  = ST_FAIL;
                     reason_nxt = REASON_CMD;
                     code_nxt   = CODE_W'({hdr.dev, hdr.cmd});
                  end
                  default: ;
               endcase
            end else if (wdog_expired) begin
               state_nxt  = ST_FAIL;
               reason_nxt = REASON_WDOG;
               code_nxt   = '0;
            end
         end
         default: ;
      endcase
   end

   // Sticky reason/code and the one-cycle console pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         reason_q      <= REASON_NONE;
         fail_code     <= '0;
         console_valid <= 1'b0;
         console_char  <= 8'd0;
      end else begin
         reason_q      <= reason_nxt;
         fail_code     <= code_nxt;
         console_valid <= putchar;
         if (putchar) console_char <= hdr.payload[7:0];
      end
   end

   // Outputs that follow directly from the state; ready is held high after settling
   always_comb begin
      tohost_ready = (state != ST_SETTLE);
      io_success   = (state == ST_PASS);
      io_failure   = (state == ST_FAIL);
   end

   assign fail_reason = reason_q;

endmodule

// File: tb/tb_harness_exit_monitor.sv
// Self-checking bench for harness_exit_monitor: vector table, directed corners, random vs. model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: random valid/heartbeat; model predicts ready from its own state.
module tb_harness_exit_monitor;

   localparam int SETTLE = 4;
   localparam int MS_SETTLE = 0;
   localparam int MS_RUN    = 1;
   localparam int MS_PASS   = 2;
   localparam int MS_FAIL   = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tohost_valid = 1'b0;
   logic [63:0] tohost_data = 64'd0;
   logic        heartbeat = 1'b0;
   logic [31:0] wdog_limit = 32'd0;
   logic        tohost_ready;
   logic        io_success;
   logic        io_failure;
   logic [1:0]  fail_reason;
   logic [31:0] fail_code;
   logic        console_valid;
   logic [7:0]  console_char;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Reference model: verdict plus a timestamp of the last watchdog restart
   int          m_mode = MS_SETTLE;
   int          m_left = SETTLE;
   int          m_last = 0;
   int          m_reason = 0;
   logic [31:0] m_code = 32'd0;
   bit          m_cv = 1'b0;
   logic [7:0]  m_cc = 8'd0;

   typedef struct {
      logic [63:0] data;
      bit          succ;
      bit          fail;
      logic [1:0]  reason;
      logic [31:0] code;
      bit          cv;
      logic [7:0]  cc;
   } vec_t;

   vec_t vecs[10];

   harness_exit_monitor #(
      .DATA_W        (64),
      .CODE_W        (32),
      .WDOG_W        (32),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .tohost_valid  (tohost_valid),
      .tohost_ready  (tohost_ready),
      .tohost_data   (tohost_data),
      .heartbeat     (heartbeat),
      .wdog_limit    (wdog_limit),
      .io_success    (io_success),
      .io_failure    (io_failure),
      .fail_reason   (fail_reason),
      .fail_code     (fail_code),
      .console_valid (console_valid),
      .console_char  (console_char)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance the model over the edge about to happen (index edge_n)
   task automatic model_step(input bit rst, input bit vld, input logic [63:0] d,
                             input bit hb, input logic [31:0] lim);
      logic [7:0]  dev;
      logic [7:0]  cmd;
      logic [31:0] code;
      dev  = d[63:56];
      cmd  = d[55:48];
      code = d[32:1];
      if (rst) begin
         m_mode = MS_SETTLE; m_left = SETTLE; m_reason = 0;
         m_code = 32'd0; m_cv = 1'b0; m_cc = 8'd0;
         return;
      end
      m_cv = 1'b0;
      if (m_mode == MS_SETTLE) begin
         m_left--;
         if (m_left == 0) begin
            m_mode = MS_RUN;
            m_last = edge_n;
         end
      end else if (m_mode == MS_RUN) begin
         if (vld) begin
            m_last = edge_n;
            if (d == 64'd0) begin
            end else if (dev == 8'd0 && d[0]) begin
               if (code == 32'd0) m_mode = MS_PASS;
               else begin m_mode = MS_FAIL; m_reason = 1; m_code = code; end
            end else if (dev == 8'd1 && cmd == 8'd1) begin
               m_cv = 1'b1; m_cc = d[7:0];
            end else begin
               m_mode = MS_FAIL; m_reason = 3; m_code = {16'h0, d[63:48]};
            end
         end else if (hb) begin
            m_last = edge_n;
         end else if (lim != 0 && longint'(edge_n - m_last) == longint'(lim) + 1) begin
            m_mode = MS_FAIL; m_reason = 2; m_code = 32'd0;
         end
      end
   endtask

   task automatic tick();
      model_step(reset, tohost_valid, tohost_data, heartbeat, wdog_limit);
      @(posedge clock);
      #1;
      edge_n++;
   endtask

   task automatic apply_reset();
      reset = 1'b1; tohost_valid = 1'b0; heartbeat = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic settle();
      repeat (SETTLE) tick();
   endtask

   task automatic check_model();
      chk("m_ready", tohost_ready, m_mode != MS_SETTLE);
      chk("m_success", io_success, m_mode == MS_PASS);
      chk("m_failure", io_failure, m_mode == MS_FAIL);
      chk("m_reason", fail_reason, m_reason);
      chk("m_code", fail_code, m_code);
      chk("m_cvalid", console_valid, m_cv);
      if (m_cv) chk("m_cchar", console_char, m_cc);
   endtask

   initial begin
      vecs[0] = '{64'h0000_0000_0000_0001, 1, 0, 2'd0, 32'h0,          0, 8'h00};
      vecs[1] = '{64'h0000_0000_0000_0007, 0, 1, 2'd1, 32'h3,          0, 8'h00};
      vecs[2] = '{64'h0203_0000_0000_0000, 0, 1, 2'd3, 32'h0203,       0, 8'h00};
      vecs[3] = '{64'h0101_0000_0000_0048, 0, 0, 2'd0, 32'h0,          1, 8'h48};
      vecs[4] = '{64'h0000_0000_0000_0000, 0, 0, 2'd0, 32'h0,          0, 8'h00};
      vecs[5] = '{64'h0000_0000_0000_0002, 0, 1, 2'd3, 32'h0,          0, 8'h00};
      vecs[6] = '{64'h0102_0000_0000_0041, 0, 1, 2'd3, 32'h0102,       0, 8'h00};
      vecs[7] = '{64'h0000_0001_0000_0001, 0, 1, 2'd1, 32'h8000_0000,  0, 8'h00};
      vecs[8] = '{64'h0001_0000_0000_0001, 1, 0, 2'd0, 32'h0,          0, 8'h00};
      vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 2'd3, 32'hFFFF,       0, 8'h00};

      // Reset state, then settle with a word already waiting
      tick();
      chk("rst_ready", tohost_ready, 0);
      chk("rst_success", io_success, 0);
      chk("rst_failure", io_failure, 0);
      chk("rst_reason", fail_reason, 0);
      chk("rst_code", fail_code, 0);
      chk("rst_cvalid", console_valid, 0);
      chk("rst_cchar", console_char, 0);
      reset = 1'b0; tohost_valid = 1'b1; tohost_data = 64'h1;
      for (int i = 0; i < SETTLE; i++) begin
         chk("settle_ready_low", tohost_ready, 0);
         tick();
      end
      chk("settle_ready_high", tohost_ready, 1);
      tick();
      tohost_valid = 1'b0;
      chk("settle_pass", io_success, 1);
      chk("settle_reason", fail_reason, 0);

      // Reset while in PASS, then pass again
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_success", io_success, 0);
      chk("midrst_failure", io_failure, 0);
      chk("midrst_ready", tohost_ready, 0);
      chk("midrst_cvalid", console_valid, 0);
      settle();
      tohost_valid = 1'b1; tohost_data = 64'h1;
      tick();
      tohost_valid = 1'b0;
      chk("midrst_repass", io_success, 1);

      // Failing exit code is sticky and later words are drained silently
      apply_reset(); settle();
      tohost_valid = 1'b1; tohost_data = 64'h7;
      tick();
      chk("fexit_failure", io_failure, 1);
      chk("fexit_reason", fail_reason, 1);
      chk("fexit_code", fail_code, 3);
      for (int i = 0; i < 20; i++) begin
         tohost_data = (i % 2 == 0) ? 64'h1 : 64'h0101_0000_0000_0041;
         tick();
         chk("fexit_no_success", io_success, 0);
         chk("fexit_stuck", io_failure, 1);
         chk("fexit_ready", tohost_ready, 1);
         chk("fexit_no_console", console_valid, 0);
      end
      tohost_valid = 1'b0;

      // Back-to-back putchar
      apply_reset(); settle();
      tohost_valid = 1'b1; tohost_data = 64'h0101_0000_0000_0048;
      tick();
      chk("con1_valid", console_valid, 1);
      chk("con1_char", console_char, 8'h48);
      tohost_data = 64'h0101_0000_0000_0069;
      tick();
      tohost_valid = 1'b0;
      chk("con2_valid", console_valid, 1);
      chk("con2_char", console_char, 8'h69);
      tick();
      chk("con_end_valid", console_valid, 0);
      chk("con_run_ready", tohost_ready, 1);
      chk("con_run_nofail", io_failure, 0);
      chk("con_run_nopass", io_success, 0);

      // Watchdog expiry at limit+1 idle edges after entering RUN
      wdog_limit = 32'd10;
      apply_reset(); settle();
      repeat (10) tick();
      chk("wdog_not_yet", io_failure, 0);
      tick();
      chk("wdog_failure", io_failure, 1);
      chk("wdog_reason", fail_reason, 2);
      chk("wdog_code", fail_code, 0);

      // Exit on the expiry cycle wins
      apply_reset(); settle();
      repeat (10) tick();
      tohost_valid = 1'b1; tohost_data = 64'h1;
      tick();
      tohost_valid = 1'b0;
      chk("prio_success", io_success, 1);
      chk("prio_failure", io_failure, 0);

      // Heartbeat every 9 cycles keeps the watchdog quiet
      apply_reset(); settle();
      for (int i = 0; i < 200; i++) begin
         heartbeat = (i % 9 == 8);
         tick();
      end
      heartbeat = 1'b0;
      chk("hb_no_failure", io_failure, 0);

      // Limit 0 disables the watchdog
      wdog_limit = 32'd0;
      apply_reset(); settle();
      repeat (250) tick();
      chk("wdog_off_no_failure", io_failure, 0);

      // Vector table: one word after settle
      for (int v = 0; v < 10; v++) begin
         apply_reset(); settle();
         tohost_valid = 1'b1; tohost_data = vecs[v].data;
         tick();
         tohost_valid = 1'b0;
         chk($sformatf("vec%0d_success", v), io_success, vecs[v].succ);
         chk($sformatf("vec%0d_failure", v), io_failure, vecs[v].fail);
         chk($sformatf("vec%0d_reason", v), fail_reason, vecs[v].reason);
         chk($sformatf("vec%0d_code", v), fail_code, vecs[v].code);
         chk($sformatf("vec%0d_cvalid", v), console_valid, vecs[v].cv);
         if (vecs[v].cv) chk($sformatf("vec%0d_cchar", v), console_char, vecs[v].cc);
      end

      // Random traffic against the model
      for (int seg = 0; seg < 6; seg++) begin
         wdog_limit = (seg % 3 == 0) ? 32'd0 : 32'($urandom_range(3, 12));
         apply_reset();
         check_model();
         for (int c = 0; c < 300; c++) begin
            int pick;
            reset = ($urandom_range(0, 199) == 0);
            heartbeat = ($urandom_range(0, 7) == 0);
            tohost_valid = ($urandom_range(0, 2) == 0);
            pick = $urandom_range(0, 99);
            if (pick < 60)      tohost_data = {8'h01, 8'h01, 40'h0, 8'($urandom)};
            else if (pick < 75) tohost_data = 64'h0;
            else if (pick < 80) tohost_data = 64'h1;
            else if (pick < 85) tohost_data = {8'h00, 23'($urandom), 32'($urandom), 1'b1};
            else if (pick < 90) tohost_data = {8'($urandom_range(2, 255)), 24'($urandom), 32'($urandom)};
            else                tohost_valid = 1'b0;
            tick();
            check_model();
         end
         reset = 1'b0; tohost_valid = 1'b0; heartbeat = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
